// File: rtl/sync_debounce.sv
// sync_debounce
//   Conditions an asynchronous, bouncy input (button, switch, slow sensor).
//   The raw input goes through a SYNC_STAGES-deep synchroniser. A level
//   change is accepted only after it has held for DEBOUNCE_CYCLES
//   consecutive checking cycles. Aborted changes are counted in a
//   saturating diagnostic counter.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst        : asynchronous reset, active low
//   raw_in     : asynchronous raw input
//   clean      : debounced level (registered)
//   rise       : one-cycle pulse, coincident with clean going 0->1
//   fall       : one-cycle pulse, coincident with clean going 1->0
//   bounce_cnt : saturating count of aborted transitions
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOUNCE_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  output logic                clean,
  output logic                rise,
  output logic                fall,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [BOUNCE_W-1:0]    bcnt_q, bcnt_d;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
    return (&v) ? v : v + BOUNCE_W'(1);
  endfunction

  // Synchroniser: only the last stage is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Entering a CHK state costs one cycle before counting starts, so a new
  // level must be seen at s for DEBOUNCE_CYCLES+1 consecutive cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      ST_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = ST_LO;
          bcnt_d  = sat_inc(bcnt_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = ST_HI;
          bcnt_d  = sat_inc(bcnt_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LO;
      end
    endcase
  end

  assign clean      = clean_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign bounce_cnt = bcnt_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: a default instance (SYNC 2, DEBOUNCE 16, BOUNCE_W 8)
// and a small instance (SYNC 2, DEBOUNCE 4, BOUNCE_W 2) share one raw input.
module tb_sync_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_in;

  logic       clean_d0, rise_d0, fall_d0;
  logic [7:0] bcnt_d0;
  logic       clean_s, rise_s, fall_s;
  logic [1:0] bcnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_debounce u_def (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clean      (clean_d0),
    .rise       (rise_d0),
    .fall       (fall_d0),
    .bounce_cnt (bcnt_d0)
  );

  sync_debounce #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .BOUNCE_W        (2)
  ) u_sml (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clean      (clean_s),
    .rise       (rise_s),
    .fall       (fall_s),
    .bounce_cnt (bcnt_s)
  );

  // Behavioural reference: history of raw samples since reset; the level seen
  // after the synchroniser is the sample taken SYNC edges earlier. A change is
  // accepted once s has differed from clean for D+1 consecutive edges; a run
  // that ends early is one bounce.
  typedef struct {
    bit clean;
    bit rise;
    bit fall;
    int run;
    int bcnt;
  } mst_t;

  bit   hist[$];
  mst_t m_def = '{default: 0};
  mst_t m_sml = '{default: 0};

  function automatic bit s_of(input int sync);
    int n;
    n = hist.size();
    return (n >= sync) ? hist[n - sync] : 1'b0;
  endfunction

  function automatic mst_t mstep(input mst_t st, input bit s, input int d, input int bmax);
    mst_t nx;
    nx = st;
    nx.rise = 1'b0;
    nx.fall = 1'b0;
    if (s != st.clean) begin
      nx.run = st.run + 1;
      if (nx.run == d + 1) begin
        nx.clean = s;
        nx.rise  = s;
        nx.fall  = !s;
        nx.run   = 0;
      end
    end else if (st.run > 0) begin
      nx.run = 0;
      if (st.bcnt < bmax) nx.bcnt = st.bcnt + 1;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_def <= '{default: 0};
      m_sml <= '{default: 0};
      hist.delete();
    end else begin
      m_def <= mstep(m_def, s_of(2), 16, 255);
      m_sml <= mstep(m_sml, s_of(2), 4, 3);
      hist.push_back(raw_in);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_models();
    chk("def_clean", int'(clean_d0), int'(m_def.clean));
    chk("def_rise",  int'(rise_d0),  int'(m_def.rise));
    chk("def_fall",  int'(fall_d0),  int'(m_def.fall));
    chk("def_bcnt",  int'(bcnt_d0),  m_def.bcnt);
    chk("sml_clean", int'(clean_s),  int'(m_sml.clean));
    chk("sml_rise",  int'(rise_s),   int'(m_sml.rise));
    chk("sml_fall",  int'(fall_s),   int'(m_sml.fall));
    chk("sml_bcnt",  int'(bcnt_s),   m_sml.bcnt);
    chk("rise_fall_excl", int'(rise_d0 & fall_d0) + int'(rise_s & fall_s), 0);
  endtask

  // Tallies of the small instance's outputs across step() calls.
  int cnt_r, cnt_f, cnt_hi;

  // Called at a negedge: drive raw for the next posedge, then compare.
  task automatic step(input bit v);
    raw_in = v;
    @(negedge clk);
    cmp_models();
    if (rise_s)  cnt_r++;
    if (fall_s)  cnt_f++;
    if (clean_s) cnt_hi++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_def"}, int'(clean_d0) + int'(rise_d0) + int'(fall_d0) + int'(bcnt_d0), 0);
    chk({nm, "_sml"}, int'(clean_s) + int'(rise_s) + int'(fall_s) + int'(bcnt_s), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_all_zero("reset_async");
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    cnt_r = 0; cnt_f = 0; cnt_hi = 0;
  endtask

  // Drive raw to v at a negedge and count rising edges (1 = first sampling
  // edge) until each instance's clean reaches v; the strobe must coincide.
  task automatic measure(input bit v, input int exp_d, input int exp_s, input string nm);
    int k, kd, ks;
    bit pd, ps;
    k = 0; kd = -1; ks = -1; pd = 1'b0; ps = 1'b0;
    raw_in = v;
    while (k < 100 && (kd < 0 || ks < 0)) begin
      @(posedge clk);
      #1;
      k++;
      if (kd < 0 && clean_d0 == v) begin
        kd = k;
        pd = v ? rise_d0 : fall_d0;
      end
      if (ks < 0 && clean_s == v) begin
        ks = k;
        ps = v ? rise_s : fall_s;
      end
    end
    chk({nm, "_lat_def"}, kd, exp_d);
    chk({nm, "_lat_sml"}, ks, exp_s);
    chk({nm, "_pulse_def"}, int'(pd), 1);
    chk({nm, "_pulse_sml"}, int'(ps), 1);
    @(negedge clk);
  endtask

  typedef struct {
    int len;
    int exp_b;
    int exp_r;
    int exp_f;
    int exp_hi;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   sat_exp[6];
    bit   v;
    int   len;

    tbl[0] = '{len: 4, exp_b: 1, exp_r: 0, exp_f: 0, exp_hi: 0};
    tbl[1] = '{len: 5, exp_b: 0, exp_r: 1, exp_f: 1, exp_hi: 5};
    tbl[2] = '{len: 1, exp_b: 1, exp_r: 0, exp_f: 0, exp_hi: 0};
    tbl[3] = '{len: 3, exp_b: 1, exp_r: 0, exp_f: 0, exp_hi: 0};
    tbl[4] = '{len: 6, exp_b: 0, exp_r: 1, exp_f: 1, exp_hi: 6};
    sat_exp = '{1, 2, 3, 3, 3, 3};

    rst    = 1'b0;
    raw_in = 1'b0;
    cnt_r = 0; cnt_f = 0; cnt_hi = 0;
    @(negedge clk);

    // Reset held while raw toggles: everything stays zero.
    for (int i = 0; i < 8; i++) begin
      step(i[0]);
      chk_all_zero("reset_hold");
    end
    raw_in = 1'b0;
    rst    = 1'b1;
    repeat (3) step(1'b0);

    // Clean step up, hold 40 cycles, then clean step down.
    measure(1'b1, 19, 7, "step_up");
    repeat (21) step(1'b1);
    chk("step_bcnt_def", int'(bcnt_d0), 0);
    chk("step_bcnt_sml", int'(bcnt_s), 0);
    measure(1'b0, 19, 7, "step_dn");
    repeat (5) step(1'b0);

    // Bounce pattern 1,0,1,1,0 then low.
    do_reset();
    step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    repeat (10) step(1'b0);
    chk("bounce_clean", int'(clean_s), 0);
    chk("bounce_rises", cnt_r, 0);
    chk("bounce_bcnt_sml", int'(bcnt_s), 2);
    chk("bounce_bcnt_def", int'(bcnt_d0), 2);

    // Pulse-length threshold table on the small instance.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      repeat (tbl[t].len) step(1'b1);
      repeat (15) step(1'b0);
      chk($sformatf("tbl%0d_bcnt", t), int'(bcnt_s), tbl[t].exp_b);
      chk($sformatf("tbl%0d_rise", t), cnt_r, tbl[t].exp_r);
      chk($sformatf("tbl%0d_fall", t), cnt_f, tbl[t].exp_f);
      chk($sformatf("tbl%0d_hi", t), cnt_hi, tbl[t].exp_hi);
      chk($sformatf("tbl%0d_clean", t), int'(clean_s), 0);
    end

    // Saturation of the 2-bit bounce counter.
    do_reset();
    for (int g = 0; g < 6; g++) begin
      step(1'b1);
      repeat (5) step(1'b0);
      chk($sformatf("sat%0d", g), int'(bcnt_s), sat_exp[g]);
    end
    chk("sat_def", int'(bcnt_d0), 6);

    // Reset in the middle of CHK_HI (counter at 2), then release with raw high.
    repeat (5) step(1'b1);
    rst = 1'b0;
    #1;
    chk_all_zero("midchk_rst");
    step(1'b1);
    step(1'b1);
    chk_all_zero("midchk_hold");
    rst = 1'b1;
    measure(1'b1, 19, 7, "post_rst");
    repeat (4) step(1'b1);

    // Randomised runs of random length against the reference model.
    do_reset();
    for (int r = 0; r < 120; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      repeat (len) step(v);
    end
    repeat (30) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
